// File: rtl/gf2n_pkg.sv
// Shared FSM state encoding and default reduction polynomials for the
// GF(2^N) power engine.
package gf2n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // x^6+x+1 and the AES polynomial x^8+x^4+x^3+x+1
  localparam logic [6:0] POLY_N6 = 7'b1000011;
  localparam logic [8:0] POLY_N8 = 9'h11B;

endpackage

// File: rtl/gf2n_mul.sv
// Combinational GF(2^N) multiplier: carry-less product reduced modulo POLY.
module gf2n_mul #(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = 7'b1000011
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  localparam logic [2*N-2:0] POLY_EXT = {{(N-2){1'b0}}, POLY};

  logic [2*N-2:0] a_ext;
  logic [2*N-2:0] prod;

  assign a_ext = {{(N-1){1'b0}}, a};

  if (POLY[N] != 1'b1) begin : g_poly_chk
    $error("gf2n_mul: POLY must have bit N set");
  end

  // Fold the high product bits back down from the top, one degree at a time.
  always_comb begin
    prod = '0;
    for (int i = 0; i < N; i++) begin
      if (b[i]) prod = prod ^ (a_ext << i);
    end
    for (int i = 2*N-2; i >= N; i--) begin
      if (prod[i]) prod = prod ^ (POLY_EXT << (i - N));
    end
    c = prod[N-1:0];
  end

endmodule

// File: rtl/gf2n_power_seq.sv
// Constant-time y = x^e over GF(2^N) using left-to-right square-and-multiply,
// behind valid/ready handshakes on both sides.
//
//   state   | meaning
//   IDLE    | waiting for an operand, in_ready high
//   RUN     | EW square-and-multiply steps, one exponent bit per cycle
//   DONE    | result presented, held until out_ready
module gf2n_power_seq
  import gf2n_pkg::*;
#(
  parameter int         N    = 6,
  parameter logic [N:0] POLY = POLY_N6,
  parameter int         EW   = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  x,
  input  logic [EW-1:0] e,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  y,
  output logic          busy
);

  localparam int         CW    = (EW > 1) ? $clog2(EW) : 1;
  localparam logic [N-1:0] ONE = N'(1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   xr_q, xr_d;
  logic [EW-1:0]  er_q, er_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [N-1:0]   y_q, y_d;
  logic           out_valid_q, out_valid_d;

  logic [N-1:0]   sq;
  logic [N-1:0]   mop;
  logic [N-1:0]   step;

  // Multiplier always runs; a zero exponent bit multiplies by one so every
  // step costs the same regardless of the exponent value.
  assign mop = er_q[cnt_q] ? xr_q : ONE;

  gf2n_mul #(.N(N), .POLY(POLY)) u_sqr (.a(acc_q), .b(acc_q), .c(sq));
  gf2n_mul #(.N(N), .POLY(POLY)) u_mul (.a(sq),    .b(mop),   .c(step));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    xr_d        = xr_q;
    er_d        = er_q;
    acc_d       = acc_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          xr_d    = x;
          er_d    = e;
          acc_d   = ONE;
          cnt_d   = CW'(EW-1);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = step;
        if (cnt_q == '0) begin
          y_d         = step;
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      xr_q        <= '0;
      er_q        <= '0;
      acc_q       <= ONE;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      xr_q        <= xr_d;
      er_q        <= er_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_valid = out_valid_q;
  assign y         = y_q;

endmodule

// File: tb/tb_gf2n_power_seq.sv
// Directed and model-based checks of gf2n_power_seq for N=6 and N=8 (AES poly).
module tb_gf2n_power_seq;
  import gf2n_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       iv6 = 1'b0, ir6, ov6, or6 = 1'b0, busy6;
  logic [5:0] x6 = '0, e6 = '0, y6;
  logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, busy8;
  logic [7:0] x8 = '0, e8 = '0, y8;

  int n_pass  = 0;
  int n_total = 0;

  gf2n_power_seq #(.N(6), .POLY(POLY_N6), .EW(6)) u6 (
    .clk(clk), .rst(rst), .in_valid(iv6), .in_ready(ir6), .x(x6), .e(e6),
    .out_valid(ov6), .out_ready(or6), .y(y6), .busy(busy6));

  gf2n_power_seq #(.N(8), .POLY(POLY_N8), .EW(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8), .e(e8),
    .out_valid(ov8), .out_ready(or8), .y(y8), .busy(busy8));

  // Shift-and-add reference, then plain repeated multiplication for the power.
  function automatic int gf_mul(int a, int b, int n, int poly);
    int r = 0;
    for (int i = 0; i < n; i++) begin
      if ((b & 1) != 0) r = r ^ a;
      b = b >> 1;
      a = a << 1;
      if ((a & (1 << n)) != 0) a = a ^ poly;
    end
    return r;
  endfunction

  function automatic int gf_pow(int xv, int ev, int n, int poly);
    int r = 1;
    for (int i = 0; i < ev; i++) r = gf_mul(r, xv, n, poly);
    return r;
  endfunction

  task automatic run_op6(input logic [5:0] xi, input logic [5:0] ei, input int stall,
                         output logic [5:0] yo, output int lat, output bit to);
    iv6 = 1'b1; x6 = xi; e6 = ei; or6 = 1'b0;
    @(posedge clk); #1;
    iv6 = 1'b0;
    lat = 0;
    while (ov6 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    to = (ov6 !== 1'b1);
    yo = y6;
    for (int k = 0; k < stall; k++) begin
      @(posedge clk); #1;
    end
    or6 = 1'b1;
    @(posedge clk); #1;
    or6 = 1'b0;
  endtask

  task automatic run_op8(input logic [7:0] xi, input logic [7:0] ei,
                         output logic [7:0] yo, output int lat, output bit to);
    iv8 = 1'b1; x8 = xi; e8 = ei; or8 = 1'b0;
    @(posedge clk); #1;
    iv8 = 1'b0;
    lat = 0;
    while (ov8 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    to = (ov8 !== 1'b1);
    yo = y8;
    or8 = 1'b1;
    @(posedge clk); #1;
    or8 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (ir6 !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", ir6); else n_pass++;
    n_total++; if (ov6 !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", ov6); else n_pass++;
    n_total++; if (busy6 !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy6); else n_pass++;
    n_total++; if (y6 !== 6'h00) $display("FAIL reset_y got %h exp 00", y6); else n_pass++;
    n_total++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || busy8 !== 1'b0 || y8 !== 8'h00)
      $display("FAIL reset_n8 got ir=%b ov=%b busy=%b y=%h exp 1 0 0 00", ir8, ov8, busy8, y8);
    else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [5:0] y; int lat; bit to;
    run_op6(6'h02, 6'd13, 0, y, lat, to);
    n_total++; if (to || y !== 6'h0A) $display("FAIL basic_y got %h (timeout %0d) exp 0a", y, to); else n_pass++;
    n_total++; if (lat != 6) $display("FAIL basic_latency got %0d exp 6", lat); else n_pass++;
    n_total++;
    if (ir6 !== 1'b1 || ov6 !== 1'b0) $display("FAIL basic_ready_return got ir=%b ov=%b exp 1 0", ir6, ov6);
    else n_pass++;
  endtask

  task automatic test_inverse();
    logic [5:0] xs [3] = '{6'h02, 6'h21, 6'h2A};
    logic [5:0] es [3] = '{6'd62, 6'd62, 6'd63};
    logic [5:0] ys [3] = '{6'h21, 6'h02, 6'h01};
    logic [5:0] y; int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      run_op6(xs[i], es[i], 1, y, lat, to);
      n_total++;
      if (to || y !== ys[i] || lat != 6)
        $display("FAIL inverse_%0d got y=%h lat=%0d exp y=%h lat=6", i, y, lat, ys[i]);
      else n_pass++;
    end
  endtask

  task automatic test_corners();
    logic [5:0] xs [3] = '{6'h00, 6'h00, 6'h15};
    logic [5:0] es [3] = '{6'd0, 6'd13, 6'd1};
    logic [5:0] ys [3] = '{6'h01, 6'h00, 6'h15};
    logic [5:0] y; int lat; bit to;
    for (int i = 0; i < 3; i++) begin
      run_op6(xs[i], es[i], 0, y, lat, to);
      n_total++;
      if (to || y !== ys[i] || lat != 6)
        $display("FAIL corner_%0d got y=%h lat=%0d exp y=%h lat=6", i, y, lat, ys[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int lat = 0;
    iv6 = 1'b1; x6 = 6'h02; e6 = 6'd13; or6 = 1'b0;
    @(posedge clk); #1;
    x6 = 6'h3F; e6 = 6'd1;
    while (ov6 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++; x6 = x6 + 6'd1;
    end
    n_total++; if (lat != 6) $display("FAIL bp_latency got %0d exp 6", lat); else n_pass++;
    for (int k = 0; k < 5; k++) begin
      n_total++;
      if (ov6 !== 1'b1 || y6 !== 6'h0A || ir6 !== 1'b0 || busy6 !== 1'b1)
        $display("FAIL bp_hold_%0d got ov=%b y=%h ir=%b busy=%b exp 1 0a 0 1", k, ov6, y6, ir6, busy6);
      else n_pass++;
      x6 = x6 + 6'd5;
      @(posedge clk); #1;
    end
    x6 = 6'h15; e6 = 6'd1; or6 = 1'b1;
    @(posedge clk); #1;
    or6 = 1'b0;
    n_total++;
    if (ov6 !== 1'b0 || ir6 !== 1'b1) $display("FAIL bp_release got ov=%b ir=%b exp 0 1", ov6, ir6);
    else n_pass++;
    @(posedge clk); #1;
    iv6 = 1'b0;
    n_total++;
    if (busy6 !== 1'b1 || ir6 !== 1'b0) $display("FAIL bp_accept got busy=%b ir=%b exp 1 0", busy6, ir6);
    else n_pass++;
    lat = 0;
    while (ov6 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    n_total++;
    if (ov6 !== 1'b1 || y6 !== 6'h15) $display("FAIL bp_next_y got ov=%b y=%h exp 1 15", ov6, y6);
    else n_pass++;
    or6 = 1'b1;
    @(posedge clk); #1;
    or6 = 1'b0;
  endtask

  task automatic test_back_to_back();
    int first = -1, second = -1;
    logic [5:0] y2 = '0;
    x6 = 6'h02; e6 = 6'd13; iv6 = 1'b1; or6 = 1'b1;
    for (int c = 1; c <= 40 && second < 0; c++) begin
      @(posedge clk); #1;
      if (ov6 === 1'b1) begin
        if (first < 0) first = c;
        else begin second = c; y2 = y6; end
      end
    end
    iv6 = 1'b0;
    n_total++; if (first != 7) $display("FAIL b2b_first got %0d exp 7", first); else n_pass++;
    n_total++;
    if (second - first != 8) $display("FAIL b2b_period got %0d exp 8", second - first); else n_pass++;
    n_total++; if (y2 !== 6'h0A) $display("FAIL b2b_y got %h exp 0a", y2); else n_pass++;
    for (int c = 0; c < 20 && !(ir6 === 1'b1 && ov6 === 1'b0); c++) begin
      @(posedge clk); #1;
    end
    or6 = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [5:0] y; int lat; bit to; int seen = 0;
    run_op6(6'h15, 6'd1, 0, y, lat, to);
    iv6 = 1'b1; x6 = 6'h02; e6 = 6'd13;
    @(posedge clk); #1;
    iv6 = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++;
    if (ov6 !== 1'b0 || ir6 !== 1'b1 || busy6 !== 1'b0 || y6 !== 6'h00)
      $display("FAIL midrun_reset got ov=%b ir=%b busy=%b y=%h exp 0 1 0 00", ov6, ir6, busy6, y6);
    else n_pass++;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (ov6 === 1'b1) seen++;
    end
    n_total++; if (seen != 0) $display("FAIL midrun_no_output got %0d pulses exp 0", seen); else n_pass++;
    run_op6(6'h02, 6'd13, 0, y, lat, to);
    n_total++;
    if (to || y !== 6'h0A || lat != 6) $display("FAIL midrun_after got y=%h lat=%0d exp 0a 6", y, lat);
    else n_pass++;
  endtask

  task automatic test_exhaustive_n6();
    logic [5:0] y; int lat; bit to; int exp_y;
    for (int xi = 0; xi < 64; xi++) begin
      for (int ei = 0; ei < 64; ei++) begin
        exp_y = gf_pow(xi, ei, 6, 'h43);
        run_op6(6'(xi), 6'(ei), int'($urandom_range(0, 2)), y, lat, to);
        n_total++;
        if (to || int'(y) != exp_y || lat != 6)
          $display("FAIL exh6 x=%h e=%0d got y=%h lat=%0d exp y=%h lat=6", xi, ei, y, lat, exp_y);
        else n_pass++;
      end
    end
  endtask

  task automatic test_n8();
    logic [7:0] xs [4] = '{8'h53, 8'h02, 8'h03, 8'h00};
    logic [7:0] es [4] = '{8'd254, 8'd8, 8'd255, 8'd0};
    logic [7:0] ys [4] = '{8'hCA, 8'h1B, 8'h01, 8'h01};
    logic [7:0] y; int lat; bit to; int xi, ei, exp_y;
    for (int i = 0; i < 4; i++) begin
      run_op8(xs[i], es[i], y, lat, to);
      n_total++;
      if (to || y !== ys[i] || lat != 8)
        $display("FAIL n8_spot_%0d got y=%h lat=%0d exp y=%h lat=8", i, y, lat, ys[i]);
      else n_pass++;
    end
    for (int i = 0; i < 32; i++) begin
      xi = int'($urandom_range(0, 255));
      ei = int'($urandom_range(0, 255));
      exp_y = gf_pow(xi, ei, 8, 'h11B);
      run_op8(8'(xi), 8'(ei), y, lat, to);
      n_total++;
      if (to || int'(y) != exp_y || lat != 8)
        $display("FAIL n8_rand x=%h e=%0d got y=%h lat=%0d exp y=%h", xi, ei, y, lat, exp_y);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_inverse();
    test_corners();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_exhaustive_n6();
    test_n8();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
